// File: rtl/ds1124_pkg.sv
// Shared DS1124 definitions for the responder and the driver: frame size,
// the responder state encoding and the bit-counter width.
package ds1124_pkg;

  localparam int DS1124_BITS = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    LATCH     = 2'd3
  } resp_state_t;

endpackage

// File: rtl/ds1124_responder_if.sv
// DS1124 3-wire link (E, CLK, D, Q) seen from the driver (master) and the
// delay device or responder (slave).
interface ds1124_if;
  logic e;
  logic sclk;
  logic d;
  logic q;

  modport master (output e, output sclk, output d, input q);
  modport slave  (input e, input sclk, input d, output q);
endinterface

// File: rtl/ds1124_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, plus a history flop
// giving single-cycle rise and fall strobes on the synchronized value.
module ds1124_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
      hist   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      hist   <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/ds1124_responder.sv
// Device-side DS1124 responder: shifts in 8-bit frames on E/CLK/D, returns the
// current delay on Q and latches the new value on E fall.
// Optional write/error counters are enabled with DS1124_RESP_STATS_EN.
module ds1124_responder
  import ds1124_pkg::*;
#(
  parameter int                     SYNC_STAGES = 2,
  parameter logic [DS1124_BITS-1:0] RESET_DELAY = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ds1124_e,
  input  logic                   ds1124_clk,
  input  logic                   ds1124_d,
  output logic                   ds1124_q,
  output logic [DS1124_BITS-1:0] delay_value,
  output logic                   delay_update,
  output logic                   frame_error,
`ifdef DS1124_RESP_STATS_EN
  output logic [15:0]            write_count,
  output logic [15:0]            error_count,
`endif
  output logic                   busy
);

  localparam int              SETTLE_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DS1124_BITS);

  logic e_s, e_rise, e_fall;
  logic clk_s, clk_rise, clk_fall;
  logic d_s, d_rise, d_fall;
  logic unused_edges;

  ds1124_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
    .clk(clk), .rst(rst), .din(ds1124_e), .sync(e_s), .rise(e_rise), .fall(e_fall)
  );
  ds1124_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .din(ds1124_clk), .sync(clk_s), .rise(clk_rise), .fall(clk_fall)
  );
  ds1124_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d (
    .clk(clk), .rst(rst), .din(ds1124_d), .sync(d_s), .rise(d_rise), .fall(d_fall)
  );

  assign unused_edges = ^{clk_s, clk_fall, d_rise, d_fall};

  resp_state_t            state_q, state_d;
  logic [DS1124_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SETTLE_W-1:0]    settle_q, settle_d;
  logic [DS1124_BITS-1:0] value_d;
  logic                   upd_d, err_d, q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      settle_q     <= '0;
      delay_value  <= RESET_DELAY;
      delay_update <= 1'b0;
      frame_error  <= 1'b0;
      ds1124_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      delay_value  <= value_d;
      delay_update <= upd_d;
      frame_error  <= err_d;
      ds1124_q     <= q_d;
    end
  end

  // The synchronizers clear on reset, so a low e_s just after reset is only
  // trusted once it has held for longer than the pipeline takes to refill.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    value_d  = delay_value;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (e_s) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_W'(SYNC_STAGES)) begin
          settle_d = '0;
          state_d  = IDLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      IDLE: begin
        if (e_rise) begin
          shreg_d = delay_value;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (e_fall) begin
          state_d = LATCH;
        end else if (clk_rise) begin
          shreg_d = {shreg_q[DS1124_BITS-2:0], d_s};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q >= CNT_FULL) begin
          value_d = shreg_q;
          upd_d   = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
    q_d = ((state_d == SHIFT) || (state_d == LATCH)) ? shreg_d[DS1124_BITS-1] : 1'b0;
  end

  assign busy = (state_q == SHIFT) || (state_q == LATCH);

`ifdef DS1124_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      write_count <= '0;
      error_count <= '0;
    end else begin
      if (upd_d) write_count <= write_count + 16'd1;
      if (err_d) error_count <= error_count + 16'd1;
    end
  end
`endif

endmodule
